// File: rtl/muldiv_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module  : muldiv_ctrl                                                    |
// | Purpose : EX-stage multiply/divide sequencer with architectural HI/LO.  |
// |           One-pass registered multiply, WIDTH-step restoring divide,     |
// |           pipeline stall generation and MTHI/MTLO servicing.             |
// | Options : DIV_ZERO_FLAG_EN - adds div_zero output and a fast            |
// |           divide-by-zero path (IDLE -> DONE, hi=src_a, lo=all ones).     |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  output logic             stall,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int           CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               accept;
  logic               zero_acc;

  // multiply operands and signedness
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_sgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;

  // divide working registers: quotient shifts in from the dividend magnitude
  logic [WIDTH-1:0]   rem, quo, dvs;
  logic               neg_q, neg_r;
  logic [WIDTH:0]     rem_sh, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt, q_fix, r_fix;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               op_sgn;

  assign accept = (state == S_IDLE) && start && !flush;

`ifdef DIV_ZERO_FLAG_EN
  assign zero_acc = accept && op[1] && (src_b == '0);
`else
  assign zero_acc = 1'b0;
`endif

  // Operand magnitudes for the divider; signed ops use absolute values
  assign op_sgn = ~op[0];
  assign mag_a  = (op_sgn && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b  = (op_sgn && src_b[WIDTH-1]) ? -src_b : src_b;

  // Full-width product; sign extension makes one multiplier serve both MULT and MULTU
  assign ext_a   = {{WIDTH{mul_sgn & mul_a[WIDTH-1]}}, mul_a};
  assign ext_b   = {{WIDTH{mul_sgn & mul_b[WIDTH-1]}}, mul_b};
  assign product = ext_a * ext_b;

  // One restoring step: shift the next dividend bit in, subtract if it fits
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, dvs};
  assign ge      = (rem_sh >= {1'b0, dvs});
  assign rem_nxt = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ge};
  assign q_fix   = neg_q ? -quo_nxt : quo_nxt;
  assign r_fix   = neg_r ? -rem_nxt : rem_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; flush abandons an in-flight operation
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (zero_acc)   state_nxt = S_DONE;
          else if (op[1]) state_nxt = S_DIV;
          else            state_nxt = S_MUL;
        end
      end
      S_MUL:   state_nxt = flush ? S_IDLE : S_DONE;
      S_DIV: begin
        if (flush)                 state_nxt = S_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; a flushed operation drops stall immediately
  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    busy  = 1'b0;
    case (state)
      S_IDLE:       stall = start & ~flush;
      S_MUL, S_DIV: begin
        stall = ~flush;
        busy  = 1'b1;
      end
      S_DONE:       done = 1'b1;
      default:      ;
    endcase
  end

  // Datapath: operand capture, divide iteration and HI/LO commit (results override MT writes)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      if ((state == S_IDLE || state == S_DONE) && mthi_we) hi <= mt_data;
      if ((state == S_IDLE || state == S_DONE) && mtlo_we) lo <= mt_data;

      if (accept) begin
        mul_a   <= src_a;
        mul_b   <= src_b;
        mul_sgn <= op_sgn;
        rem     <= '0;
        quo     <= mag_a;
        dvs     <= mag_b;
        neg_q   <= op_sgn & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        neg_r   <= op_sgn & src_a[WIDTH-1];
        cnt     <= '0;
        if (zero_acc) begin
          hi <= src_a;
          lo <= {WIDTH{1'b1}};
        end
      end

      if (state == S_MUL && !flush) {hi, lo} <= product;

      if (state == S_DIV) begin
        cnt <= cnt + 1'b1;
        rem <= rem_nxt;
        quo <= quo_nxt;
        if (!flush && cnt == CNT_LAST) begin
          lo <= q_fix;
          hi <= r_fix;
        end
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  // Divide-by-zero flag accompanies the done pulse of the fast path
  always_ff @(posedge clk) begin
    if (!resetn) div_zero <= 1'b0;
    else         div_zero <= zero_acc;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_muldiv_ctrl                                                 |
// | Purpose : Self-checking bench for muldiv_ctrl: vector table, directed    |
// |           corner sequences and random ops against an arithmetic model.   |
// |           Define DIV_ZERO_FLAG_EN to exercise the divide-by-zero path.   |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_muldiv_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             resetn, start, flush, mthi_we, mtlo_we;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a, src_b, mt_data;
  logic             stall, done, busy;
  logic [WIDTH-1:0] hi, lo;
`ifdef DIV_ZERO_FLAG_EN
  logic             div_zero;
`endif

  int errors = 0;
  int checks = 0;

  muldiv_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .flush   (flush),
    .mthi_we (mthi_we),
    .mtlo_we (mtlo_we),
    .mt_data (mt_data),
    .stall   (stall),
    .done    (done),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero(div_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: product/quotient from plain arithmetic on the architectural rules
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint      pa, pb, p;
    logic [31:0] am, bm, q, r;
    bit          sg;
    sg = !o[0];
    if (!o[1]) begin
      pa = sg ? longint'($signed(a)) : longint'({32'b0, a});
      pb = sg ? longint'($signed(b)) : longint'({32'b0, b});
      p  = pa * pb;
      eh = p[63:32];
      el = p[31:0];
      return;
    end
`ifdef DIV_ZERO_FLAG_EN
    if (b == 0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
      return;
    end
`endif
    am = (sg && a[31]) ? -a : a;
    bm = (sg && b[31]) ? -b : b;
    if (bm == 0) begin
      q = 32'hFFFF_FFFF;
      r = am;
    end else begin
      q = am / bm;
      r = am % bm;
    end
    if (sg && (a[31] ^ b[31])) q = -q;
    if (sg && a[31])           r = -r;
    eh = r;
    el = q;
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] b);
    if (!o[1]) return 2;
`ifdef DIV_ZERO_FLAG_EN
    if (b == 0) return 1;
`endif
    return WIDTH + 1;
  endfunction

  // Runs one op with start held through DONE, checks latency, stall, result and single done
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string nm);
    logic [31:0] eh, el;
    int          cyc;
    bit          got, bad;
    model(o, a, b, eh, el);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 chk({nm, " stall_accept"}, 64'(stall), 64'd1);
    cyc = 0; got = 0; bad = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
      else if (!stall || !busy) bad = 1;
    end
    chk({nm, " done_seen"}, 64'(got), 64'd1);
    chk({nm, " stall_busy_while_running"}, 64'(bad), 64'd0);
    chk({nm, " latency"}, 64'(cyc), 64'(latency(o, b)));
    chk({nm, " stall_at_done"}, 64'(stall), 64'd0);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
`ifdef DIV_ZERO_FLAG_EN
    chk({nm, " div_zero"}, 64'(div_zero), 64'(o[1] && b == 0));
`endif
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({nm, " single_done"}, 64'({done, busy, stall}), 64'd0);
  endtask

  initial begin
    vec_t        vecs[12];
    int          nvec;
    logic [31:0] hsave, lsave, eh, el, ra, rb;
    logic [1:0]  ro;
    int          cyc;
    bit          seen;

    nvec = 0;
    vecs[nvec++] = '{2'b00, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[nvec++] = '{2'b01, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA};
    vecs[nvec++] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[nvec++] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[nvec++] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[nvec++] = '{2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2};
    vecs[nvec++] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
    vecs[nvec++] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
`ifdef DIV_ZERO_FLAG_EN
    vecs[nvec++] = '{2'b11, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF};
`else
    vecs[nvec++] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[nvec++] = '{2'b10, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'd1};
`endif

    resetn = 1'b0; start = 1'b0; flush = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0;
    op = 2'b00; src_a = '0; src_b = '0; mt_data = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset outputs", {hi, lo}, 64'd0);
    chk("reset ctrl", 64'({stall, done, busy}), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post reset idle", 64'({stall, done, busy}), 64'd0);

    // vector table; expected values are checked both directly and via the model
    for (int i = 0; i < nvec; i++) begin
      model(vecs[i].op, vecs[i].a, vecs[i].b, eh, el);
      chk($sformatf("vec%0d model_vs_table", i), {eh, el}, {vecs[i].exp_hi, vecs[i].exp_lo});
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
    end

    // flush at divide iteration 10: no commit, no done
    hsave = hi; lsave = lo;
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1 chk("flush stall", 64'(stall), 64'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1 chk("flush idle", 64'({busy, stall, done}), 64'd0);
    chk("flush hilo kept", {hi, lo}, {hsave, lsave});
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("flush no done", 64'(seen), 64'd0);
    do_op(2'b01, 32'd5, 32'd6, "multu_after_flush");

    // flush in IDLE blocks acceptance
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd3;
    #1 chk("idle flush stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1 chk("idle flush not accepted", 64'({busy, done}), 64'd0);

    // MTHI / MTLO in IDLE, then MULTU 2*3 with start held through DONE
    @(negedge clk);
    mthi_we = 1'b1; mt_data = 32'h1234_5678;
    @(negedge clk);
    mthi_we = 1'b0;
    chk("mthi", 64'(hi), 64'h1234_5678);
    mtlo_we = 1'b1; mt_data = 32'hCAFE_F00D;
    @(negedge clk);
    mtlo_we = 1'b0;
    chk("mtlo", 64'(lo), 64'hCAFE_F00D);
    do_op(2'b01, 32'd2, 32'd3, "multu_2x3");

    // MT write concurrent with accept lands, then the result overwrites it
    @(negedge clk);
    start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd6;
    mthi_we = 1'b1; mt_data = 32'h77;
    @(negedge clk);
    mthi_we = 1'b0;
    chk("mt with accept", 64'(hi), 64'h77);
    @(negedge clk);
    chk("mt overwritten by result", {hi, lo}, 64'd30);
    @(negedge clk);
    start = 1'b0;

    // MT writes ignored while a divide is busy
    @(negedge clk);
    start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd7;
    repeat (3) @(negedge clk);
    mthi_we = 1'b1; mtlo_we = 1'b1; mt_data = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi_we = 1'b0; mtlo_we = 1'b0;
    chk("mt ignored busy", {hi, lo}, {32'd0, 32'd30});
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy mt done", 64'(done), 64'd1);
    chk("busy mt result", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);
    start = 1'b0;

    // reset during divide iteration 5 aborts and clears
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    repeat (6) @(negedge clk);
    resetn = 1'b0; start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midop reset hilo", {hi, lo}, 64'd0);
    chk("midop reset ctrl", 64'({stall, busy, done}), 64'd0);

    // random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      do_op(ro, ra, rb, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Sequencing controller for the EX-stage multiply/divide resource and the architectural HI/LO registers. It accepts one MULT/MULTU/DIV/DIVU request from the EX stage and runs the operation: a registered one-pass multiply, or a 32-iteration restoring divide. While the operation is in flight it drives a pipeline stall, then commits the result to HI/LO. It also services MTHI/MTLO writes and exposes HI/LO to the MFHI/MFLO path.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits; the divide takes WIDTH iterations.

Ports:
clk  in  1  system clock; all state changes on rising edge
resetn  in  1  synchronous, active-low reset
start  in  1  EX stage holds a mul/div instruction; held high by the pipeline while stalled
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src_a  in  WIDTH  rs operand (dividend / multiplicand)
src_b  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  exception/flush of the EX instruction
mthi_we  in  1  MTHI write enable
mtlo_we  in  1  MTLO write enable
mt_data  in  WIDTH  MTHI/MTLO data
stall  out  1  hold the pipeline (combinational)
done  out  1  one-cycle pulse: HI/LO updated by the operation
busy  out  1  state is MUL or DIV
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset (resetn) is synchronous and active-low.
- Reset values: state IDLE; hi=0, lo=0, done=0, busy=0, stall=0; iteration counter 0. Reset applied mid-operation aborts the operation immediately.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 and flush=0 → accept the request. Latch op and operands; stall=1 in this cycle.
  - op[1]=0 → next state MUL. op[1]=1 → next state DIV with counter=0.
- MUL:
  - Computes the 2*WIDTH product: signed for MULT, unsigned for MULTU.
  - At the edge leaving MUL: {hi,lo}=product; next state DONE. stall=1 in this cycle.
- DIV:
  - Operates on operand magnitudes (abs for DIV, raw for DIVU); one restoring step per cycle.
  - Steps counter 0..WIDTH-1, with stall=1 throughout.
  - At the edge where counter=WIDTH-1: lo=quotient, hi=remainder; next state DONE.
  - DIV sign fixup: quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
- DONE:
  - done=1, stall=0, next state IDLE.
  - start is ignored here, because it still belongs to the completing instruction; there is no re-execution.
- Latency: MUL keeps stall high 2 cycles and pulses done on cycle 2. DIV keeps stall high WIDTH+1 cycles and pulses done on cycle WIDTH+1 (cycle 0 = accept).
- stall = (IDLE & start & ~flush) | MUL | DIV.
- flush:
  - In MUL or DIV: next state IDLE, no HI/LO write, stall=0 in that cycle.
  - In IDLE: start is not accepted.
- MTHI/MTLO:
  - Honoured only in IDLE or DONE; hi/lo take mt_data at the next edge.
  - Ignored while busy.
  - Simultaneous mthi_we and accepted start in IDLE: the MT write happens; the later result overwrites it.
- Divide by zero (without the feature macro): no exception. The algorithm runs unmodified and produces unsigned q=all-ones, r=dividend magnitude, followed by the normal sign fixup.

Optional Feature:
DIV_ZERO_FLAG_EN
- Defined:
  - Adds output div_zero (1 bit, reset 0).
  - A DIV/DIVU accepted with src_b=0 goes IDLE→DONE directly, skipping the iterations: stall=1 for the accept cycle only.
  - Writes hi=src_a and lo={WIDTH{1'b1}}; div_zero=1 together with done.
- Undefined: the port is absent, and divide-by-zero runs the full WIDTH iterations as described above.

Test Plan:
- MULT src_a=0xFFFFFFFE, src_b=3 → stall high 2 cycles, done on cycle 2, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU src_a=0xFFFFFFFE, src_b=3 → hi=0x00000002, lo=0xFFFFFFFA.
- DIV src_a=0xFFFFFFF9 (-7), src_b=2 → stall high 33 cycles, done on cycle 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 → lo=14, hi=2.
- DIV accepted, flush=1 at iteration 10 → stall=0 that cycle, hi/lo unchanged, done never pulses; a following MULTU 5*6 gives lo=30, hi=0.
- mthi_we with mt_data=0x12345678 in IDLE → hi=0x12345678 next cycle. Then MULTU 2*3 with start held through DONE → exactly one done pulse, lo=6, hi=0.
- resetn=0 for one cycle during DIV iteration 5 → hi=lo=0, stall=0, busy=0 on the next cycle. With DIV_ZERO_FLAG_EN: DIVU 9/0 → done on cycle 1, div_zero=1, hi=9, lo=0xFFFFFFFF.
